// File: rtl/mux_gate_pkg.sv
// Shared definitions for the mux-built logic unit.
//   op_e : 3-bit operation select (AND, OR, XOR, NAND, NOR, XNOR, PASS A, NOT A)
//   LUT  : per-op 4-entry truth table, indexed by {a,b}
//   OP_W : width of the op select / op tag
package mux_gate_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_PASS = 3'b110,
        OP_NOTA = 3'b111
    } op_e;

    // Bit k of each entry is the result for {a,b} == k.
    localparam logic [3:0] LUT [0:7] = '{
        4'b1000,  // AND
        4'b1110,  // OR
        4'b0110,  // XOR
        4'b0111,  // NAND
        4'b0001,  // NOR
        4'b1001,  // XNOR
        4'b1100,  // PASS A
        4'b0011   // NOT A
    };

endpackage

// File: rtl/mux_gate_cell.sv
// One-bit gate built purely from 2:1 multiplexers.
//   a, b : operand bits
//   lut  : truth table, lut[{a,b}] is the result
//   y    : selected truth-table bit
// The first rank of two muxes selects on b, the final mux selects on a.
module mux_gate_cell (
    input  logic       a,
    input  logic       b,
    input  logic [3:0] lut,
    output logic       y
);

    logic m_a0;
    logic m_a1;

    assign m_a0 = b ? lut[1] : lut[0];
    assign m_a1 = b ? lut[3] : lut[2];
    assign y    = a ? m_a1 : m_a0;

endmodule

// File: rtl/mux_gate_alu.sv
// WIDTH-bit bitwise logic unit feeding a FIFO_DEPTH-entry result queue.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready is low only when the queue is full)
//   in_a, in_b, in_op   : operands and op select, sampled on accepted beats
//   out_valid/out_ready : result handshake at the queue head
//   out_y, out_op       : head result and its op tag, forced to zero while empty
//   result_cnt          : saturating pop counter, present only when
//                         MUX_GATE_ALU_RESULT_CNT_EN is defined
module mux_gate_alu
    import mux_gate_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
`ifdef MUX_GATE_ALU_RESULT_CNT_EN
    output logic [15:0]      result_cnt,
`endif
    output logic [OP_W-1:0]  out_op
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] y_comb;
    logic [3:0]       lut_sel;

    logic [WIDTH-1:0] mem_y  [FIFO_DEPTH];
    logic [OP_W-1:0]  mem_op [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;

    assign lut_sel = LUT[in_op];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        mux_gate_cell u_cell (
            .a   (in_a[i]),
            .b   (in_b[i]),
            .lut (lut_sel),
            .y   (y_comb[i])
        );
    end

    // in_ready depends on count only, so a full queue never accepts even if popping.
    assign in_ready  = (count_q != CNT_W'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_y  = out_valid ? mem_y[rd_ptr_q]  : '0;
    assign out_op = out_valid ? mem_op[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointer overflow is the modulo wrap.
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_y[wr_ptr_q]  <= y_comb;
            mem_op[wr_ptr_q] <= in_op;
        end
    end

`ifdef MUX_GATE_ALU_RESULT_CNT_EN
    logic [15:0] result_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_cnt_q <= '0;
        end else if (pop && (result_cnt_q != 16'hFFFF)) begin
            result_cnt_q <= result_cnt_q + 16'd1;
        end
    end

    assign result_cnt = result_cnt_q;
`endif

endmodule
